execute_stage: RTL and testbench

Execute stage of the five-stage RV32I pipeline, between decode/register-read and the data-cache stage. It combines three parts:
- the DEC/EX pipeline register;
- a combinational 32-bit ALU;
- the EX/MEM pipeline register.

It carries the register-write enable, write-back address, data-cache control and rs2 store data alongside the ALU result.

---
 rtl/execute_stage_if.sv | 48 ++++
 rtl/execute_stage.sv | 139 +++++++++++++
 tb/tb_execute_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_if
// Description : Bundles the execute stage's instruction inputs and its
//               EX/MEM outputs. The optional flush input exists only when
//               EXEC_FLUSH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_stage_if;
  logic [31:0] dataReg1;
  logic [31:0] dataReg2;
  logic [31:0] immValueIn;
  logic [4:0]  ALUop;
  logic [4:0]  writeBackAddrIn;
  logic        writeEnableReg;
  logic [1:0]  dataCacheControlIn;
`ifdef EXEC_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] dataOut;
  logic [31:0] dataRs2Out;
  logic [1:0]  dataCacheControlOut;
  logic        writeEnableOut;
  logic [4:0]  writeBackAddrOut;

  // Upstream side: drives the instruction, observes the EX/MEM outputs
  modport master (
`ifdef EXEC_FLUSH_EN
    output flush,
`endif
    output dataReg1, dataReg2, immValueIn, ALUop,
    output writeBackAddrIn, writeEnableReg, dataCacheControlIn,
    input  dataOut, dataRs2Out, dataCacheControlOut,
    input  writeEnableOut, writeBackAddrOut
  );

  // Execute-stage side
  modport slave (
`ifdef EXEC_FLUSH_EN
    input  flush,
`endif
    input  dataReg1, dataReg2, immValueIn, ALUop,
    input  writeBackAddrIn, writeEnableReg, dataCacheControlIn,
    output dataOut, dataRs2Out, dataCacheControlOut,
    output writeEnableOut, writeBackAddrOut
  );
endinterface
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : RV32I execute stage: DEC/EX register, combinational 32-bit
//               ALU, EX/MEM register. Two-cycle latency, one instruction per
//               cycle. Optional macro EXEC_FLUSH_EN adds a flush input that
//               loads a bubble into the DEC/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage (
  input  wire logic     clk,
  input  wire logic     resetIn,
  execute_stage_if.slave bus
);

  // ALUop[3:0] operation codes; ALUop[4] selects the immediate as operand B
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  // Stage 1 (DEC/EX) state and next-state
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  op_q,  op_d;
  logic [4:0]  wa_q,  wa_d;
  logic        we_q,  we_d;
  logic [1:0]  cc_q,  cc_d;

  // Stage 2 (EX/MEM) state
  logic [31:0] res_q;
  logic [31:0] st_q;
  logic [4:0]  wa2_q;
  logic        we2_q;
  logic [1:0]  cc2_q;

  // ALU operands and result
  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;

  // Stage-1 next state: capture the inputs, or a bubble when flushed
  always_comb begin
    rs1_d = bus.dataReg1;
    rs2_d = bus.dataReg2;
    imm_d = bus.immValueIn;
    op_d  = bus.ALUop;
    wa_d  = bus.writeBackAddrIn;
    we_d  = bus.writeEnableReg;
    cc_d  = bus.dataCacheControlIn;
`ifdef EXEC_FLUSH_EN
    if (bus.flush) begin
      rs1_d = '0;
      rs2_d = '0;
      imm_d = '0;
      op_d  = '0;
      wa_d  = '0;
      we_d  = 1'b0;
      cc_d  = 2'b00;
    end
`endif
  end

  // DEC/EX register; reset leaves an all-zero bubble (ADD 0+0, no write)
  always_ff @(posedge clk) begin
    if (resetIn) begin
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      op_q  <= '0;
      wa_q  <= '0;
      we_q  <= 1'b0;
      cc_q  <= 2'b00;
    end else begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      imm_q <= imm_d;
      op_q  <= op_d;
      wa_q  <= wa_d;
      we_q  <= we_d;
      cc_q  <= cc_d;
    end
  end

  assign alu_b = op_q[4] ? imm_q : rs2_q;
  assign shamt = alu_b[4:0];

  // ALU: A is always rs1; unused codes 11-15 yield zero
  always_comb begin
    alu_res = '0;
    unique case (op_q[3:0])
      OP_ADD:   alu_res = rs1_q + alu_b;
      OP_SUB:   alu_res = rs1_q - alu_b;
      OP_AND:   alu_res = rs1_q & alu_b;
      OP_OR:    alu_res = rs1_q | alu_b;
      OP_XOR:   alu_res = rs1_q ^ alu_b;
      OP_SLL:   alu_res = rs1_q << shamt;
      OP_SRL:   alu_res = rs1_q >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(rs1_q) >>> shamt);
      OP_SLT:   alu_res = {31'd0, ($signed(rs1_q) < $signed(alu_b))};
      OP_SLTU:  alu_res = {31'd0, (rs1_q < alu_b)};
      OP_PASSB: alu_res = alu_b;
      default:  alu_res = '0;
    endcase
  end

  // EX/MEM register; store data is always stage-1 rs2, never the immediate
  always_ff @(posedge clk) begin
    if (resetIn) begin
      res_q <= '0;
      st_q  <= '0;
      wa2_q <= '0;
      we2_q <= 1'b0;
      cc2_q <= 2'b00;
    end else begin
      res_q <= alu_res;
      st_q  <= rs2_q;
      wa2_q <= wa_q;
      we2_q <= we_q;
      cc2_q <= cc_q;
    end
  end

  assign bus.dataOut             = res_q;
  assign bus.dataRs2Out          = st_q;
  assign bus.dataCacheControlOut = cc2_q;
  assign bus.writeEnableOut      = we2_q;
  assign bus.writeBackAddrOut    = wa2_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Randomized scoreboard bench for execute_stage. Expected
//               outputs are queued with the clock edge after which they must
//               be visible; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

  typedef struct {
    int unsigned due;
    logic [31:0] d;
    logic [31:0] r2;
    logic [1:0]  cc;
    logic        we;
    logic [4:0]  wa;
  } exp_t;

  logic clk = 1'b0;
  logic resetIn = 1'b1;
  int unsigned edge_cnt = 0;
  int errors = 0;
  int checks = 0;
  exp_t q[$];

  execute_stage_if bus ();

  execute_stage dut (
    .clk     (clk),
    .resetIn (resetIn),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference ALU written straight from the operation table
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] r2, input logic [31:0] imm);
    logic [31:0] b;
    int sh;
    logic signed [31:0] sa;
    b  = op[4] ? imm : r2;
    sh = int'(b % 32);
    sa = a;
    case (int'(op[3:0]))
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return sa >>> sh;
      8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9:  return ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t zero_exp(input int unsigned due);
    exp_t e;
    e.due = due; e.d = '0; e.r2 = '0; e.cc = 2'b00; e.we = 1'b0; e.wa = '0;
    return e;
  endfunction

  // Drive one instruction; if use_k, the data result is the given constant
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [4:0] wa, input logic we,
                       input logic [1:0] cc, input logic fl, input logic use_k,
                       input logic [31:0] kd);
    exp_t e;
    logic flushed;
    @(negedge clk);
    resetIn = 1'b0;
    bus.dataReg1 = a;
    bus.dataReg2 = r2;
    bus.immValueIn = imm;
    bus.ALUop = op;
    bus.writeBackAddrIn = wa;
    bus.writeEnableReg = we;
    bus.dataCacheControlIn = cc;
`ifdef EXEC_FLUSH_EN
    bus.flush = fl;
    flushed = fl;
`else
    flushed = 1'b0;
`endif
    if (flushed) begin
      e = zero_exp(edge_cnt + 2);
    end else begin
      e.due = edge_cnt + 2;
      e.d   = use_k ? kd : model(op, a, r2, imm);
      e.r2  = r2;
      e.cc  = cc;
      e.we  = we;
      e.wa  = wa;
    end
    q.push_back(e);
  endtask

  // Assert reset for one edge: drop everything due from that edge on
  task automatic do_reset();
    int unsigned e_rst;
    @(negedge clk);
    resetIn = 1'b1;
    e_rst = edge_cnt + 1;
    while (q.size() > 0 && q[$].due >= e_rst) void'(q.pop_back());
    q.push_back(zero_exp(e_rst));
    q.push_back(zero_exp(e_rst + 1));
  endtask

  // Monitor: compare every expectation that has come due
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= edge_cnt) begin
      e = q.pop_front();
      checks++;
      if (e.due != edge_cnt || bus.dataOut !== e.d || bus.dataRs2Out !== e.r2 ||
          bus.dataCacheControlOut !== e.cc || bus.writeEnableOut !== e.we ||
          bus.writeBackAddrOut !== e.wa) begin
        errors++;
        $display("FAIL out@edge%0d(due %0d): got d=%h r2=%h cc=%b we=%b wa=%0d, want d=%h r2=%h cc=%b we=%b wa=%0d",
                 edge_cnt, e.due, bus.dataOut, bus.dataRs2Out, bus.dataCacheControlOut,
                 bus.writeEnableOut, bus.writeBackAddrOut, e.d, e.r2, e.cc, e.we, e.wa);
      end
    end
  end

  initial begin
`ifdef EXEC_FLUSH_EN
    bus.flush = 1'b0;
`endif
    // Reset held for two cycles
    do_reset();
    do_reset();
    // ADD 5+7 -> 12, rd=3 written
    issue(5'd0, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b1, 32'd12);
    // Back-to-back stream
    issue(5'd1, 32'd5, 32'd7, 32'd0, 5'd4, 1'b1, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFE);
    issue(5'd7, 32'h8000_0000, 32'd4, 32'd0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b1, 32'hF800_0000);
    issue(5'd9, 32'd1, 32'd2, 32'd0, 5'd6, 1'b1, 2'b00, 1'b0, 1'b1, 32'd1);
    issue(5'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd7, 1'b1, 2'b00, 1'b0, 1'b1, 32'd1);
    // Immediate select, store: address 0xFC, store data rs2
    issue(5'h10, 32'h100, 32'hDEAD, 32'hFFFF_FFFC, 5'd0, 1'b0, 2'b10, 1'b0, 1'b1, 32'hFC);
    // Shift masking, PASSB, unused code
    issue(5'd5, 32'd1, 32'h23, 32'd0, 5'd8, 1'b1, 2'b00, 1'b0, 1'b1, 32'd8);
    issue(5'h1A, 32'h5555, 32'h77, 32'h1234_5000, 5'd9, 1'b1, 2'b00, 1'b0, 1'b1, 32'h1234_5000);
    issue(5'd13, 32'hFFFF, 32'hAAAA, 32'd0, 5'd10, 1'b1, 2'b11, 1'b0, 1'b1, 32'd0);
    // Two in flight, then reset discards both
    issue(5'd0, 32'd1, 32'd1, 32'd0, 5'd11, 1'b1, 2'b01, 1'b0, 1'b0, 32'd0);
    issue(5'd0, 32'd2, 32'd2, 32'd0, 5'd12, 1'b1, 2'b10, 1'b0, 1'b0, 32'd0);
    do_reset();
    issue(5'd3, 32'hF0, 32'h0F, 32'd0, 5'd13, 1'b1, 2'b00, 1'b0, 1'b1, 32'hFF);
`ifdef EXEC_FLUSH_EN
    // Flushed load becomes a bubble; next instruction completes
    issue(5'h10, 32'h40, 32'h9, 32'h4, 5'd14, 1'b1, 2'b01, 1'b1, 1'b0, 32'd0);
    issue(5'd2, 32'hFF00, 32'h0FF0, 32'd0, 5'd15, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0F00);
`endif
    // Randomized stream with occasional reset (and flush when present)
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] a, b2, im;
      r  = int'($urandom_range(0, 29));
      a  = $urandom;
      b2 = $urandom;
      im = $urandom;
      if (r == 0) begin
        do_reset();
      end else begin
        if (r == 2) a = 32'h8000_0000;
        if (r == 3) b2 = 32'hFFFF_FFFF;
        issue(5'($urandom_range(0, 31)), a, b2, im, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              (r == 1), 1'b0, 32'd0);
      end
    end
`ifdef EXEC_FLUSH_EN
    @(negedge clk);
    bus.flush = 1'b0;
`endif
    // Drain with a bounded wait
    repeat (4) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never compared, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
